// File: rtl/core_pkg.sv
// Shared definitions for the core instruction sequencer: inst bus layout,
// the idle encoding and the sequencer state type.
package core_pkg;

  localparam int INST_W = 34;
  localparam int SRAM_AW = 11;

  localparam int ACC_EN_B   = 33;
  localparam int CEN_PMEM_B = 32;
  localparam int WEN_PMEM_B = 31;
  localparam int A_PMEM_LSB = 20;
  localparam int CEN_XMEM_B = 19;
  localparam int WEN_XMEM_B = 18;
  localparam int A_XMEM_LSB = 7;
  localparam int OFIFO_RD_B = 6;
  localparam int L0_RD_B    = 3;
  localparam int L0_WR_B    = 2;
  localparam int EXECUTE_B  = 1;
  localparam int LOAD_B     = 0;

  // Both SRAMs disabled (active-low enables high), every other field zero.
  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    IDLE, W_RD, W_PE, W_WAIT, A_RD, EXEC, DRAIN_RD, DRAIN_WR, NEXT
  } seq_state_t;

endpackage

// File: rtl/xmem_l0_loader.sv
// Issues n_i sequential XMEM reads from base_i, then one extra cycle so the
// one-cycle-late L0 write of the final word can land.
module xmem_l0_loader #(
  parameter int addr_bw = 11,
  parameter int CNT_W   = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [addr_bw-1:0] base_i,
  input  logic [CNT_W-1:0]   n_i,
  output logic               rd_o,
  output logic [addr_bw-1:0] addr_o,
  output logic               l0_wr_o,
  output logic               last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             l0_wr_q;

  assign rd_o    = en_i && (cnt_q < n_i);
  assign last_o  = en_i && (cnt_q == n_i);
  assign addr_o  = base_i + addr_bw'(cnt_q);
  assign l0_wr_o = l0_wr_q;

  always_comb begin
    cnt_d = '0;
    if (en_i && !last_o) cnt_d = cnt_q + 1'b1;
  end

  // SRAM data arrives one cycle after the read, so the L0 write trails it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      l0_wr_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      l0_wr_q <= rd_o;
    end
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Convolution tile sequencer: per kernel offset loads weights, streams
// activations, then drains the OFIFO into PMEM with accumulation.
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 11,
  parameter int kij_bw  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  input  logic [kij_bw-1:0]  kij_num,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] a_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic               ofifo_valid,
  output logic [INST_W-1:0]  inst,
  output logic               busy,
  output logic               done
);

  localparam int PH_W  = $clog2(row + col + 1);
  localparam int CNT_W = (len_bw > PH_W) ? len_bw : PH_W;

  seq_state_t         state_q, state_d;
  logic [kij_bw-1:0]  kij_q, kij_d, kn_q, kn_d;
  logic [len_bw-1:0]  len_q, len_d, o_q, o_d;
  logic [CNT_W-1:0]   ph_q, ph_d;
  logic [addr_bw-1:0] w_base_q, w_base_d, a_base_q, a_base_d, p_base_q, p_base_d;
  logic [INST_W-1:0]  inst_q, inst_d;

  logic               ld_en, ld_rd, ld_l0_wr, ld_last;
  logic [addr_bw-1:0] ld_base, ld_addr;
  logic [CNT_W-1:0]   ld_n;
  logic               last_kij;

  assign ld_en    = (state_q == W_RD) || (state_q == A_RD);
  assign ld_base  = (state_q == A_RD) ? a_base_q + addr_bw'(kij_q) * addr_bw'(len_q)
                                      : w_base_q + addr_bw'(kij_q) * addr_bw'(row);
  assign ld_n     = (state_q == A_RD) ? CNT_W'(len_q) : CNT_W'(row);
  assign last_kij = (kij_q == kn_q - 1'b1);

  xmem_l0_loader #(.addr_bw(addr_bw), .CNT_W(CNT_W)) u_loader (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (ld_en),
    .base_i  (ld_base),
    .n_i     (ld_n),
    .rd_o    (ld_rd),
    .addr_o  (ld_addr),
    .l0_wr_o (ld_l0_wr),
    .last_o  (ld_last)
  );

  always_comb begin
    state_d  = state_q;
    kij_d    = kij_q;
    kn_d     = kn_q;
    len_d    = len_q;
    o_d      = o_q;
    ph_d     = ph_q;
    w_base_d = w_base_q;
    a_base_d = a_base_q;
    p_base_d = p_base_q;
    inst_d   = IDLE_INST;

    if (ld_rd) begin
      inst_d[CEN_XMEM_B]              = 1'b0;
      inst_d[A_XMEM_LSB +: addr_bw]   = ld_addr;
    end
    inst_d[L0_WR_B] = ld_l0_wr;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = (len == '0) ? len_bw'(1) : len;
          kn_d     = (kij_num == '0) ? kij_bw'(1) : kij_num;
          w_base_d = w_base;
          a_base_d = a_base;
          p_base_d = p_base;
          kij_d    = '0;
          state_d  = W_RD;
        end
      end
      W_RD: begin
        if (ld_last) begin
          ph_d    = '0;
          state_d = W_PE;
        end
      end
      W_PE: begin
        inst_d[L0_RD_B] = 1'b1;
        inst_d[LOAD_B]  = 1'b1;
        ph_d            = ph_q + 1'b1;
        if (ph_q == CNT_W'(row - 1)) begin
          ph_d    = '0;
          state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        ph_d = ph_q + 1'b1;
        if (ph_q == CNT_W'(row + col - 1)) begin
          ph_d    = '0;
          state_d = A_RD;
        end
      end
      A_RD: begin
        if (ld_last) begin
          ph_d    = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        inst_d[L0_RD_B]   = 1'b1;
        inst_d[EXECUTE_B] = 1'b1;
        ph_d              = ph_q + 1'b1;
        if (ph_q == CNT_W'(len_q) - 1'b1) begin
          ph_d    = '0;
          o_d     = '0;
          state_d = DRAIN_RD;
        end
      end
      DRAIN_RD: begin
        if (ofifo_valid) begin
          inst_d[OFIFO_RD_B]            = 1'b1;
          inst_d[CEN_PMEM_B]            = 1'b0;
          inst_d[A_PMEM_LSB +: addr_bw] = p_base_q + addr_bw'(o_q);
          state_d                       = DRAIN_WR;
        end
      end
      DRAIN_WR: begin
        // First kernel offset overwrites PMEM; later ones accumulate onto it.
        inst_d[CEN_PMEM_B]            = 1'b0;
        inst_d[WEN_PMEM_B]            = 1'b0;
        inst_d[A_PMEM_LSB +: addr_bw] = p_base_q + addr_bw'(o_q);
        inst_d[ACC_EN_B]              = (kij_q != '0);
        if (o_q != len_q - 1'b1) begin
          o_d     = o_q + 1'b1;
          state_d = DRAIN_RD;
        end else begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (!last_kij) begin
          kij_d   = kij_q + 1'b1;
          state_d = W_RD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      kij_q    <= '0;
      kn_q     <= '0;
      len_q    <= '0;
      o_q      <= '0;
      ph_q     <= '0;
      w_base_q <= '0;
      a_base_q <= '0;
      p_base_q <= '0;
      inst_q   <= IDLE_INST;
    end else begin
      state_q  <= state_d;
      kij_q    <= kij_d;
      kn_q     <= kn_d;
      len_q    <= len_d;
      o_q      <= o_d;
      ph_q     <= ph_d;
      w_base_q <= w_base_d;
      a_base_q <= a_base_d;
      p_base_q <= p_base_d;
      inst_q   <= inst_d;
    end
  end

  assign inst = inst_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == NEXT) && last_kij;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: bus events are collected per tile and
// compared with an event list derived from the tile configuration.
module tb_core_seq_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int LW  = 11;
  localparam int KW  = 4;
  localparam logic [33:0] IDLE_I = 34'h1_800C_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [KW-1:0] kij_num = '0;
  logic [AW-1:0] w_base = '0, a_base = '0, p_base = '0;
  logic          ofifo_valid = 1'b1;
  logic [33:0]   inst;
  logic          busy, done;

  always #5 clk = ~clk;

  core_seq_ctrl #(.row(ROW), .col(COL), .addr_bw(AW), .len_bw(LW), .kij_bw(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .kij_num(kij_num),
    .w_base(w_base), .a_base(a_base), .p_base(p_base), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ofifo_valid source: fixed level or random
  bit   ov_rand  = 1'b0;
  logic ov_level = 1'b1;
  always @(negedge clk) begin
    if (ov_rand) ofifo_valid = ($urandom_range(0, 3) != 0);
    else         ofifo_valid = ov_level;
  end

  // bus monitor
  logic [AW-1:0] obs_xrd[$];
  logic [AW-1:0] obs_pr[$];
  logic [AW:0]   obs_pw[$];
  int   n_load = 0, n_exec = 0, n_done = 0, n_viol = 0;
  logic prev_rd = 1'b0;

  always @(negedge clk) begin
    if (!inst[19]) obs_xrd.push_back(inst[17:7]);
    if (inst[2] !== prev_rd) n_viol++;
    prev_rd = !inst[19];
    if (inst[18] !== 1'b1) n_viol++;
    if (inst[5:4] !== 2'b00) n_viol++;
    if (inst[19] && inst[17:7] != '0) n_viol++;
    if (inst[32] && inst[30:20] != '0) n_viol++;
    if (inst[0]) n_load++;
    if (inst[1]) n_exec++;
    if (inst[3] !== (inst[0] ^ inst[1])) n_viol++;
    if (inst[0] && inst[1]) n_viol++;
    if (!inst[32] && inst[31]) obs_pr.push_back(inst[30:20]);
    if (inst[6] !== (!inst[32] && inst[31])) n_viol++;
    if (!inst[32] && !inst[31]) obs_pw.push_back({inst[33], inst[30:20]});
    if (inst[33] && !(!inst[32] && !inst[31])) n_viol++;
    if (done) n_done++;
  end

  // reference event lists
  logic [AW-1:0] exp_xrd[$];
  logic [AW:0]   exp_pw[$];
  int exp_load, exp_exec;

  task automatic build_model(input int l_in, input int k_in, input int wb, input int ab, input int pb);
    int L, K;
    logic [AW:0] v;
    L = (l_in == 0) ? 1 : l_in;
    K = (k_in == 0) ? 1 : k_in;
    exp_xrd.delete();
    exp_pw.delete();
    for (int k = 0; k < K; k++) begin
      for (int i = 0; i < ROW; i++) exp_xrd.push_back(AW'((wb + k * ROW + i) % 2048));
      for (int i = 0; i < L; i++)   exp_xrd.push_back(AW'((ab + k * L + i) % 2048));
    end
    for (int k = 0; k < K; k++)
      for (int o = 0; o < L; o++) begin
        v = {(k != 0), AW'((pb + o) % 2048)};
        exp_pw.push_back(v);
      end
    exp_load = ROW * K;
    exp_exec = L * K;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    obs_xrd.delete();
    obs_pr.delete();
    obs_pw.delete();
    n_load = 0; n_exec = 0; n_done = 0; n_viol = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic start_tile(input int l, input int k, input int wb, input int ab, input int pb);
    len = LW'(l); kij_num = KW'(k);
    w_base = AW'(wb); a_base = AW'(ab); p_base = AW'(pb);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = 0;
    while (n_done == 0 && c < budget) begin
      cyc();
      c++;
    end
    check({tag, ".done_seen"}, (n_done != 0), 1);
    cyc();
    check({tag, ".idle_after"}, {busy, done}, 2'b00);
  endtask

  task automatic compare(input string tag);
    check({tag, ".xrd_n"}, obs_xrd.size(), exp_xrd.size());
    for (int i = 0; i < exp_xrd.size() && i < obs_xrd.size(); i++)
      check($sformatf("%s.xrd[%0d]", tag, i), obs_xrd[i], exp_xrd[i]);
    check({tag, ".pw_n"}, obs_pw.size(), exp_pw.size());
    for (int i = 0; i < exp_pw.size() && i < obs_pw.size(); i++)
      check($sformatf("%s.pw[%0d]", tag, i), obs_pw[i], exp_pw[i]);
    check({tag, ".pr_n"}, obs_pr.size(), exp_pw.size());
    for (int i = 0; i < exp_pw.size() && i < obs_pr.size(); i++)
      check($sformatf("%s.pr[%0d]", tag, i), obs_pr[i], exp_pw[i][AW-1:0]);
    check({tag, ".loads"}, n_load, exp_load);
    check({tag, ".execs"}, n_exec, exp_exec);
    check({tag, ".done_n"}, n_done, 1);
    check({tag, ".rules"}, n_viol, 0);
  endtask

  task automatic run_tile(input string tag, input int l, input int k, input int wb, input int ab, input int pb);
    clear_mon();
    build_model(l, k, wb, ab, pb);
    start_tile(l, k, wb, ab, pb);
    wait_done(tag, 3000);
    compare(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // reset held for three cycles, then idle without start
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("reset_state", {inst, busy, done}, {IDLE_I, 2'b00});
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("idle_no_start", {inst, busy, done}, {IDLE_I, 2'b00});
    end

    run_tile("single_kij", 4, 1, 0, 64, 100);
    run_tile("three_kij", 4, 3, 0, 64, 100);

    // OFIFO stall at drain entry
    clear_mon();
    build_model(4, 1, 0, 64, 100);
    ov_level = 1'b0;
    start_tile(4, 1, 0, 64, 100);
    c = 0;
    while (n_exec < 4 && c < 200) begin cyc(); c++; end
    check("stall.reach_drain", (n_exec >= 4), 1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("stall.idle_bus", {inst, busy}, {IDLE_I, 1'b1});
    end
    ov_level = 1'b1;
    cyc();
    check("stall.valid_edge", {ofifo_valid, inst[6], busy}, 3'b101);
    cyc();
    check("stall.first_ofifo_rd", inst[6], 1'b1);
    wait_done("stall", 3000);
    compare("stall");

    // start pulsed during EXEC with a different configuration
    clear_mon();
    build_model(4, 2, 0, 64, 100);
    start_tile(4, 2, 0, 64, 100);
    c = 0;
    while (n_exec < 1 && c < 200) begin cyc(); c++; end
    check("busy_start.in_exec", {(n_exec >= 1), busy}, 2'b11);
    start_tile(7, 5, 500, 300, 900);
    wait_done("busy_start", 3000);
    repeat (3) cyc();
    check("busy_start.stay_idle", busy, 1'b0);
    compare("busy_start");

    // reset during DRAIN_WR of output 2
    clear_mon();
    start_tile(4, 1, 0, 64, 100);
    c = 0;
    while (obs_pr.size() < 3 && c < 200) begin cyc(); c++; end
    check("rst_mid.reach_o2", obs_pr.size(), 3);
    reset = 1'b0;
    #1;
    check("rst_mid.async", {inst, busy, done}, {IDLE_I, 2'b00});
    cyc();
    check("rst_mid.next_edge", {inst, busy, done}, {IDLE_I, 2'b00});
    cyc();
    check("rst_mid.no_partial_wr", obs_pw.size(), 2);
    reset = 1'b1;
    cyc();
    run_tile("after_reset", 4, 1, 0, 64, 100);

    // zero len / kij_num, address wrap-around
    run_tile("zero_cfg", 0, 0, 5, 9, 13);
    run_tile("wrap", 3, 2, 2040, 2046, 2046);

    // randomized tiles with random OFIFO readiness
    ov_rand = 1'b1;
    for (int r = 0; r < 6; r++)
      run_tile($sformatf("rand%0d", r), $urandom_range(0, 6), $urandom_range(0, 4),
               $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047));
    ov_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Instruction sequencer for `core`. Drives the 34-bit `inst` bus so one convolution tile runs without host intervention.
- For each kernel offset (kij), it performs these steps in order:
  - Load weights: XMEM → L0 → PE array.
  - Stream activations: XMEM → L0 → execute.
  - Drain the OFIFO through SFP into PMEM, accumulating across kij.
- Sits between the testbench/host and `core`. The host only preloads XMEM and pulses `start`.

Parameters:
- row, 8, PE array rows (weight/activation vectors per kij load)
- col, 8, PE array columns
- addr_bw, 11, SRAM address width (XMEM and PMEM)
- len_bw, 11, width of activation-count input
- kij_bw, 4, width of kernel-offset count input

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to run a tile; ignored unless in IDLE
- len  input  len_bw  activation vectors (= outputs) per kij; sampled at start; 0 treated as 1
- kij_num  input  kij_bw  number of kernel offsets; sampled at start; 0 treated as 1
- w_base  input  addr_bw  XMEM base of weights; sampled at start
- a_base  input  addr_bw  XMEM base of activations; sampled at start
- p_base  input  addr_bw  PMEM base of psums; sampled at start
- ofifo_valid  input  1  from core; OFIFO holds a full output vector
- inst  output  34  core instruction bus (bit map below)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the tile completes

Behaviour:
- inst bit map:
  - [33] acc_en
  - [32] cen_pmem (active-low)
  - [31] wen_pmem (active-low)
  - [30:20] a_pmem
  - [19] cen_xmem (active-low)
  - [18] wen_xmem (active-low)
  - [17:7] a_xmem
  - [6] ofifo_rd
  - [5:4] reserved, always 0
  - [3] l0_rd
  - [2] l0_wr
  - [1] execute
  - [0] load
- Idle encoding IDLE_INST = 34'h1_800C_0000: both SRAMs disabled, all other fields 0.
  - Driven during reset, in IDLE, and on every cycle/field not explicitly asserted below.
- Reset values: inst = IDLE_INST, busy = 0, done = 0, all counters 0, state = IDLE.
- inst is registered: a field decided in cycle t appears on the bus in cycle t+1.
- wen_xmem is never driven low; the host writes XMEM only while busy = 0.
- SRAM read latency is 1 cycle. L0 writes (l0_wr) lag the matching XMEM read by one cycle.
- Address arithmetic is modulo 2^addr_bw; wrap-around is silent. All counters are sized so `len` and `kij_num` maxima are reachable.
- FSM:
  - IDLE: on start, latch inputs, set kij = 0 → W_RD.
  - W_RD (row+1 cycles):
    - Cycles 0..row-1: cen_xmem = 0, a_xmem = w_base + kij*row + i.
    - Cycles 1..row: l0_wr = 1.
    - → W_PE.
  - W_PE (row cycles): l0_rd = 1, load = 1 → W_WAIT.
  - W_WAIT (row+col cycles): idle encoding, lets weights settle → A_RD.
  - A_RD (len+1 cycles): same pattern as W_RD with a_xmem = a_base + kij*len + i → EXEC.
  - EXEC (len cycles): l0_rd = 1, execute = 1 → DRAIN_RD.
  - DRAIN_RD, output o:
    - Stall with idle encoding while ofifo_valid = 0.
    - When ofifo_valid = 1: ofifo_rd = 1, cen_pmem = 0, wen_pmem = 1, a_pmem = p_base + o → DRAIN_WR.
  - DRAIN_WR: cen_pmem = 0, wen_pmem = 0, a_pmem = p_base + o, acc_en = (kij != 0).
    - If o < len-1: o++ → DRAIN_RD.
    - Else → NEXT.
  - NEXT (1 cycle):
    - If kij < kij_num-1: kij++ → W_RD.
    - Else: done = 1 in this cycle → IDLE.
- Simultaneous events:
  - start while busy is ignored, and the latched configuration is unchanged.
  - start in the same cycle as the NEXT→IDLE transition is ignored; start is accepted only in IDLE.
- Reset asserted mid-operation: immediate return to IDLE with idle encoding. No partial PMEM write is issued after reset asserts.
- No timeout: a missing ofifo_valid stalls DRAIN_RD indefinitely with busy = 1.

Decomposition:
- Shared package `core_pkg` holds:
  - Instruction bit-position constants (ACC_EN_B … LOAD_B).
  - IDLE_INST.
  - State enum `seq_state_t` (IDLE, W_RD, W_PE, W_WAIT, A_RD, EXEC, DRAIN_RD, DRAIN_WR, NEXT).
- One sub-module: `xmem_l0_loader`.
  - Counter that issues N sequential XMEM reads from a base address, plus the one-cycle-delayed l0_wr.
  - Instantiated once and reused by W_RD and A_RD.

Test Plan:
- Reset low for 3 cycles, then high → inst = 34'h1_800C_0000, busy = 0, done = 0 throughout; no state change without start.
- row = col = 8, len = 4, kij_num = 1, w_base = 0, a_base = 64, p_base = 100, ofifo_valid tied 1 → expect:
  - XMEM reads at 0..7 then 64..67.
  - 8 load cycles, then 4 execute cycles.
  - PMEM writes at 100..103, each exactly once, with acc_en = 0.
  - One done pulse, then busy = 0.
- Same configuration with kij_num = 3:
  - Weight reads at 0..7, 8..15, 16..23.
  - Activation reads at 64..67, 68..71, 72..75.
  - PMEM writes with acc_en = 0 on kij 0 only, acc_en = 1 on kij 1 and 2.
  - 12 PMEM writes total.
- ofifo_valid held 0 for 10 cycles at entry to DRAIN_RD → inst stays at idle encoding with busy = 1; the first ofifo_rd occurs one cycle after ofifo_valid rises.
- Pulse start during EXEC with different len/bases → ignored; the addresses of the running tile are unchanged and there is exactly one done pulse.
- Assert reset during DRAIN_WR of output 2 → next edge shows inst = idle encoding and busy = 0; a fresh start then runs a full tile correctly.
